n64_si_bridge: RTL and testbench

//  Serial bridge between the RCP serial bus (n64_clk/n64_rsp in, n64_pif out) and port B of the

---
 rtl/n64_pif_pkg.sv | 32 +++
 rtl/n64_si_bridge_if.sv | 10 +
 rtl/si_edge_sync.sv | 28 ++
 rtl/n64_si_bridge.sv | 243 ++++++++++++++++++++++++
 tb/tb_n64_si_bridge.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/n64_pif_pkg.sv
// Shared definitions for the RCP serial-interface bridge to PIF RAM.
// Word framing widens by one bit when N64_SI_PARITY_EN is defined.
package n64_pif_pkg;

  localparam logic [1:0] SI_OP_RD_WORD  = 2'b00;
  localparam logic [1:0] SI_OP_WR_WORD  = 2'b01;
  localparam logic [1:0] SI_OP_RD_BLOCK = 2'b10;
  localparam logic [1:0] SI_OP_WR_BLOCK = 2'b11;

  localparam int unsigned PIF_RAM_WORDS = 16;
  localparam int unsigned PIF_ADDR_W    = $clog2(PIF_RAM_WORDS);
  localparam logic [PIF_ADDR_W-1:0] PIF_LAST_ADDR = PIF_ADDR_W'(PIF_RAM_WORDS - 1);

`ifdef N64_SI_PARITY_EN
  localparam int unsigned SI_WORD_BITS = 33;  // 32 data bits plus odd parity
`else
  localparam int unsigned SI_WORD_BITS = 32;
`endif

  typedef enum logic [2:0] {
    IDLE, CMD, WDATA, WWRITE, RFETCH, TURN, RDATA, DONE
  } si_state_e;

  function automatic logic op_is_block(input logic [1:0] op);
    return (op == SI_OP_RD_BLOCK) || (op == SI_OP_WR_BLOCK);
  endfunction

  function automatic logic op_is_write(input logic [1:0] op);
    return !((op == SI_OP_RD_WORD) || (op == SI_OP_RD_BLOCK));
  endfunction

endpackage

// File: rtl/n64_si_bridge_if.sv
// PIF RAM port B as seen by the serial bridge (master) and the RAM (slave).
interface n64_si_bridge_if;
  logic [n64_pif_pkg::PIF_ADDR_W-1:0] ram_address;
  logic                               ram_wren;
  logic [31:0]                        ram_wdata;
  logic [31:0]                        ram_rdata;

  modport master (output ram_address, ram_wren, ram_wdata, input ram_rdata);
  modport slave  (input ram_address, ram_wren, ram_wdata, output ram_rdata);
endinterface

// File: rtl/si_edge_sync.sv
// Multi-stage synchroniser for an asynchronous level with single-clk rise/fall pulses.
module si_edge_sync #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign rise = sync_q[STAGES-1] & ~prev_q;
  assign fall = ~sync_q[STAGES-1] & prev_q;
endmodule

// File: rtl/n64_si_bridge.sv
// RCP serial bus to PIF RAM port B bridge: word/block read and write commands.
// Define N64_SI_PARITY_EN to add an odd-parity bit after every data word.
module n64_si_bridge import n64_pif_pkg::*; #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TURNAROUND  = 2,
  parameter int unsigned TIMEOUT     = 4096
) (
  input  logic                  clk,
  input  logic                  reset_l,
  input  logic                  n64_clk,
  input  logic                  n64_rsp,
  output logic                  n64_pif,
  n64_si_bridge_if.master       ram,
  output logic                  busy,
  output logic                  cmd_done,
  output logic [1:0]            cmd_op,
  output logic                  frame_err
);
  localparam logic [11:0] TO_LAST = 12'(TIMEOUT - 1);

  si_state_e              state_q, state_d;
  logic [5:0]             bit_cnt_q, bit_cnt_d;
  logic [31:0]            shift_q, shift_d;
  logic [1:0]             op_q, op_d;
  logic                   first_q, first_d;
  logic [11:0]            to_cnt_q, to_cnt_d;
  logic                   pif_q, pif_d;
  logic [PIF_ADDR_W-1:0]  addr_q, addr_d;
  logic                   wren_q, wren_d;
  logic [31:0]            wdata_q, wdata_d;
  logic                   done_q, done_d;
  logic [1:0]             cmd_op_q, cmd_op_d;
  logic                   err_q, err_d;
`ifdef N64_SI_PARITY_EN
  logic                   rpar_q, rpar_d;
`endif

  logic                   clk_rise, clk_fall;
  logic [SYNC_STAGES-1:0] rsp_sync_q;
  logic                   rsp_s;

  si_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_clk_sync (
    .clk(clk), .rst_n(reset_l), .d(n64_clk), .rise(clk_rise), .fall(clk_fall)
  );

  // Same depth as the clock path so rsp_s lines up with the detected rise.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) rsp_sync_q <= '1;
    else          rsp_sync_q <= {rsp_sync_q[SYNC_STAGES-2:0], n64_rsp};
  end
  assign rsp_s = rsp_sync_q[SYNC_STAGES-1];

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    op_d      = op_q;
    first_d   = first_q;
    to_cnt_d  = '0;
    pif_d     = pif_q;
    addr_d    = addr_q;
    wren_d    = 1'b0;
    wdata_d   = wdata_q;
    done_d    = 1'b0;
    cmd_op_d  = cmd_op_q;
    err_d     = 1'b0;
`ifdef N64_SI_PARITY_EN
    rpar_d    = rpar_q;
`endif

    unique case (state_q)
      IDLE: begin
        pif_d = 1'b1;
        if (clk_rise && !rsp_s) begin
          bit_cnt_d = '0;
          state_d   = CMD;
        end
      end
      CMD: if (clk_rise) begin
        shift_d   = {shift_q[30:0], rsp_s};
        bit_cnt_d = bit_cnt_q + 6'd1;
        if (bit_cnt_q == 6'd7) begin
          // Command byte is {shift_q[6:0], rsp_s}: op in [7:6], word address in [3:0].
          op_d      = shift_q[6:5];
          addr_d    = op_is_block(shift_q[6:5]) ? '0 : {shift_q[2:0], rsp_s};
          bit_cnt_d = '0;
          first_d   = 1'b1;
          state_d   = op_is_write(shift_q[6:5]) ? WDATA : RFETCH;
        end
      end
      WDATA: if (clk_rise) begin
        shift_d   = {shift_q[30:0], rsp_s};
        bit_cnt_d = bit_cnt_q + 6'd1;
        if (bit_cnt_q == 6'(SI_WORD_BITS - 1)) begin
`ifdef N64_SI_PARITY_EN
          if (^{shift_q, rsp_s}) begin
            wren_d  = 1'b1;
            wdata_d = shift_q;
            state_d = WWRITE;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
`else
          wren_d  = 1'b1;
          wdata_d = {shift_q[30:0], rsp_s};
          state_d = WWRITE;
`endif
        end
      end
      WWRITE: begin
        if (op_is_block(op_q) && addr_q != PIF_LAST_ADDR) begin
          addr_d    = addr_q + 1'b1;
          bit_cnt_d = '0;
          state_d   = WDATA;
        end else begin
          state_d = DONE;
        end
      end
      RFETCH: begin
        // bit_cnt_q[0] marks the wait cycle for the synchronous RAM read.
        if (bit_cnt_q == 6'd0) begin
          bit_cnt_d = 6'd1;
        end else if (first_q) begin
          shift_d   = ram.ram_rdata;
          bit_cnt_d = '0;
          state_d   = TURN;
`ifdef N64_SI_PARITY_EN
          rpar_d    = ~^ram.ram_rdata;
`endif
        end else begin
          // Later block words start immediately, replacing the fall that ended bit 0.
          pif_d     = ram.ram_rdata[31];
          shift_d   = {ram.ram_rdata[30:0], 1'b0};
          bit_cnt_d = 6'd1;
          state_d   = RDATA;
`ifdef N64_SI_PARITY_EN
          rpar_d    = ~^ram.ram_rdata;
`endif
        end
      end
      TURN: if (clk_fall) begin
        if (bit_cnt_q == 6'(TURNAROUND - 1)) begin
          bit_cnt_d = '0;
          state_d   = RDATA;
        end else begin
          bit_cnt_d = bit_cnt_q + 6'd1;
        end
      end
      RDATA: if (clk_fall) begin
        if (bit_cnt_q < 6'(SI_WORD_BITS)) begin
`ifdef N64_SI_PARITY_EN
          pif_d = (bit_cnt_q == 6'd32) ? rpar_q : shift_q[31];
`else
          pif_d = shift_q[31];
`endif
          shift_d   = {shift_q[30:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 6'd1;
        end else if (op_is_block(op_q) && addr_q != PIF_LAST_ADDR) begin
          addr_d    = addr_q + 1'b1;
          bit_cnt_d = '0;
          first_d   = 1'b0;
          state_d   = RFETCH;
        end else begin
          pif_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        done_d   = 1'b1;
        cmd_op_d = op_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Mid-frame watchdog; a write already on ram_wren (wren_q) is left to finish.
    if (state_q != IDLE && state_q != DONE) begin
      if (clk_rise) begin
        to_cnt_d = '0;
      end else if (to_cnt_q == TO_LAST) begin
        err_d   = 1'b1;
        pif_d   = 1'b1;
        wren_d  = 1'b0;
        done_d  = 1'b0;
        state_d = IDLE;
      end else begin
        to_cnt_d = to_cnt_q + 12'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
      op_q      <= '0;
      first_q   <= 1'b0;
      to_cnt_q  <= '0;
      pif_q     <= 1'b1;
      addr_q    <= '0;
      wren_q    <= 1'b0;
      wdata_q   <= '0;
      done_q    <= 1'b0;
      cmd_op_q  <= '0;
      err_q     <= 1'b0;
`ifdef N64_SI_PARITY_EN
      rpar_q    <= 1'b0;
`endif
    end else begin
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      op_q      <= op_d;
      first_q   <= first_d;
      to_cnt_q  <= to_cnt_d;
      pif_q     <= pif_d;
      addr_q    <= addr_d;
      wren_q    <= wren_d;
      wdata_q   <= wdata_d;
      done_q    <= done_d;
      cmd_op_q  <= cmd_op_d;
      err_q     <= err_d;
`ifdef N64_SI_PARITY_EN
      rpar_q    <= rpar_d;
`endif
    end
  end

  assign n64_pif         = pif_q;
  assign ram.ram_address = addr_q;
  assign ram.ram_wren    = wren_q;
  assign ram.ram_wdata   = wdata_q;
  assign busy            = (state_q != IDLE);
  assign cmd_done        = done_q;
  assign cmd_op          = cmd_op_q;
  assign frame_err       = err_q;
endmodule

// File: tb/tb_n64_si_bridge.sv
// Directed bench for n64_si_bridge: RCP-side serial driver plus a PIF RAM model.
module tb_n64_si_bridge;
  import n64_pif_pkg::*;

  localparam int unsigned HALF    = 120;  // n64_clk half period: 12 clk cycles
  localparam int unsigned TIMEOUT = 4096;

  logic       clk     = 1'b0;
  logic       reset_l = 1'b0;
  logic       n64_clk = 1'b0;
  logic       n64_rsp = 1'b1;
  logic       n64_pif, busy, cmd_done, frame_err;
  logic [1:0] cmd_op;

  n64_si_bridge_if ram_if ();

  n64_si_bridge #(.SYNC_STAGES(2), .TURNAROUND(2), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_l(reset_l), .n64_clk(n64_clk), .n64_rsp(n64_rsp), .n64_pif(n64_pif),
    .ram(ram_if), .busy(busy), .cmd_done(cmd_done), .cmd_op(cmd_op), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // PIF RAM port B model with a bench-side preload path.
  logic [31:0] mem [PIF_RAM_WORDS];
  logic        bd_we   = 1'b0;
  logic [3:0]  bd_addr = '0;
  logic [31:0] bd_data = '0;

  always @(posedge clk) begin
    if (bd_we)               mem[bd_addr] <= bd_data;
    else if (ram_if.ram_wren) mem[ram_if.ram_address] <= ram_if.ram_wdata;
    ram_if.ram_rdata <= mem[ram_if.ram_address];
  end

  // Event monitor: counts strobes and logs every RAM write.
  int          wr_cnt   = 0;
  int          done_cnt = 0;
  int          err_cnt  = 0;
  logic [3:0]  wr_addr_log [64];
  logic [31:0] wr_data_log [64];

  always @(posedge clk) begin
    if (ram_if.ram_wren) begin
      wr_addr_log[wr_cnt % 64] <= ram_if.ram_address;
      wr_data_log[wr_cnt % 64] <= ram_if.ram_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    if (cmd_done)  done_cnt <= done_cnt + 1;
    if (frame_err) err_cnt  <= err_cnt + 1;
  end

  int passed = 0;
  int failed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bd_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    bd_addr = a;
    bd_data = d;
    bd_we   = 1'b1;
    @(negedge clk);
    bd_we   = 1'b0;
  endtask

  // One n64_clk period: data set up in the low phase, rise, fall at the end.
  task automatic si_bit(input logic b);
    n64_rsp = b;
    #(HALF);
    n64_clk = 1'b1;
    #(HALF);
    n64_clk = 1'b0;
  endtask

  // One read period: n64_pif is sampled just before the rise.
  task automatic si_read(output logic s);
    n64_rsp = 1'b1;
    #(HALF);
    s = n64_pif;
    n64_clk = 1'b1;
    #(HALF);
    n64_clk = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] cmd);
    si_bit(1'b0);
    for (int i = 7; i >= 0; i--) si_bit(cmd[i]);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) si_bit(w[i]);
`ifdef N64_SI_PARITY_EN
    si_bit(~^w);
`endif
  endtask

  task automatic recv_word(output logic [31:0] w);
    logic b;
    w = '0;
    for (int i = 0; i < 32; i++) begin
      si_read(b);
      w = {w[30:0], b};
    end
`ifdef N64_SI_PARITY_EN
    si_read(b);
    check("rd_parity", 32'(b), 32'(~^w));
`endif
  endtask

  task automatic settle();
    repeat (10) @(negedge clk);
  endtask

  initial begin
    int          w0, d0, e0, n;
    logic        b;
    logic [31:0] w;
    logic [31:0] pat;

    repeat (5) @(negedge clk);
    check("rst_pif",       32'(n64_pif), 32'd1);
    check("rst_busy",      32'(busy), 32'd0);
    check("rst_done",      32'(cmd_done), 32'd0);
    check("rst_op",        32'(cmd_op), 32'd0);
    check("rst_err",       32'(frame_err), 32'd0);
    check("rst_wren",      32'(ram_if.ram_wren), 32'd0);
    check("rst_addr",      32'(ram_if.ram_address), 32'd0);
    check("rst_wdata",     ram_if.ram_wdata, 32'd0);
    reset_l = 1'b1;
    repeat (5) @(negedge clk);

    // 1: single word write
    w0 = wr_cnt; d0 = done_cnt;
    send_cmd(8'h45);
    send_word(32'hDEADBEEF);
    settle();
    check("t1_wr_count", 32'(wr_cnt - w0), 32'd1);
    check("t1_wr_addr",  32'(wr_addr_log[w0 % 64]), 32'd5);
    check("t1_wr_data",  wr_data_log[w0 % 64], 32'hDEADBEEF);
    check("t1_done",     32'(done_cnt - d0), 32'd1);
    check("t1_op",       32'(cmd_op), 32'(SI_OP_WR_WORD));
    check("t1_busy",     32'(busy), 32'd0);

    // 2: single word read with turnaround
    bd_write(4'd9, 32'h12345678);
    d0 = done_cnt;
    send_cmd(8'h09);
    si_read(b); check("t2_turn0", 32'(b), 32'd1);
    si_read(b); check("t2_turn1", 32'(b), 32'd1);
    recv_word(w);
    check("t2_data", w, 32'h12345678);
    settle();
    check("t2_done", 32'(done_cnt - d0), 32'd1);
    check("t2_op",   32'(cmd_op), 32'(SI_OP_RD_WORD));
    check("t2_pif_idle", 32'(n64_pif), 32'd1);

    // 3: block write (address field ignored) then block read
    w0 = wr_cnt; d0 = done_cnt;
    send_cmd(8'hC5);
    for (int k = 0; k < 16; k++) send_word(32'(32'h0101_0101 * k));
    settle();
    check("t3_wr_count", 32'(wr_cnt - w0), 32'd16);
    for (int k = 0; k < 16; k++) begin
      check("t3_wr_addr", 32'(wr_addr_log[(w0 + k) % 64]), 32'(k));
      check("t3_wr_data", wr_data_log[(w0 + k) % 64], 32'(32'h0101_0101 * k));
    end
    check("t3_wr_done", 32'(done_cnt - d0), 32'd1);
    check("t3_wr_op",   32'(cmd_op), 32'(SI_OP_WR_BLOCK));

    d0 = done_cnt;
    send_cmd(8'h8A);
    si_read(b); check("t3_turn0", 32'(b), 32'd1);
    si_read(b); check("t3_turn1", 32'(b), 32'd1);
    for (int k = 0; k < 16; k++) begin
      recv_word(w);
      check("t3_rd_word", w, 32'(32'h0101_0101 * k));
    end
    settle();
    check("t3_rd_done", 32'(done_cnt - d0), 32'd1);
    check("t3_rd_op",   32'(cmd_op), 32'(SI_OP_RD_BLOCK));
    check("t3_rd_pif",  32'(n64_pif), 32'd1);

    // 4: n64_clk stops mid-word -> timeout abort, then normal frame
    w0 = wr_cnt; d0 = done_cnt; e0 = err_cnt;
    pat = 32'hCAFEF00D;
    send_cmd(8'h47);
    for (int i = 31; i > 21; i--) si_bit(pat[i]);
    n = 0;
    while (!frame_err && n < int'(TIMEOUT) + 200) begin
      @(negedge clk);
      n++;
    end
    check("t4_err_seen",   32'(frame_err), 32'd1);
    check("t4_err_window", 32'(n >= int'(TIMEOUT) - 16 && n <= int'(TIMEOUT) - 4), 32'd1);
    check("t4_busy",       32'(busy), 32'd0);
    settle();
    check("t4_no_write",   32'(wr_cnt - w0), 32'd0);
    check("t4_err_count",  32'(err_cnt - e0), 32'd1);
    check("t4_no_done",    32'(done_cnt - d0), 32'd0);
    send_cmd(8'h47);
    send_word(pat);
    settle();
    check("t4_wr_count", 32'(wr_cnt - w0), 32'd1);
    check("t4_wr_addr",  32'(wr_addr_log[w0 % 64]), 32'd7);
    check("t4_wr_data",  wr_data_log[w0 % 64], 32'hCAFEF00D);
    check("t4_done",     32'(done_cnt - d0), 32'd1);

    // 5: reset in the middle of a read, then RD_WORD of address 0
    bd_write(4'd0, 32'hA5C30F96);
    send_cmd(8'h09);
    si_read(b);
    si_read(b);
    for (int i = 0; i < 8; i++) si_read(b);
    repeat (8) @(negedge clk);
    check("t5_pif_bit23", 32'(n64_pif), 32'd0);
    check("t5_busy_pre",  32'(busy), 32'd1);
    reset_l = 1'b0;
    #1;
    check("t5_rst_pif",  32'(n64_pif), 32'd1);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_wren", 32'(ram_if.ram_wren), 32'd0);
    @(negedge clk);
    reset_l = 1'b1;
    repeat (5) @(negedge clk);
    d0 = done_cnt;
    send_cmd(8'h00);
    si_read(b);
    si_read(b);
    recv_word(w);
    check("t5_data", w, 32'hA5C30F96);
    settle();
    check("t5_done", 32'(done_cnt - d0), 32'd1);
    check("t5_pif",  32'(n64_pif), 32'd1);

`ifdef N64_SI_PARITY_EN
    // 6: write parity error drops the word, correct parity accepted
    w0 = wr_cnt; e0 = err_cnt;
    pat = 32'h0000_0001;
    send_cmd(8'h42);
    for (int i = 31; i >= 0; i--) si_bit(pat[i]);
    si_bit(1'b1);
    settle();
    check("t6_bad_err",   32'(err_cnt - e0), 32'd1);
    check("t6_bad_write", 32'(wr_cnt - w0), 32'd0);
    send_cmd(8'h42);
    for (int i = 31; i >= 0; i--) si_bit(pat[i]);
    si_bit(1'b0);
    settle();
    check("t6_good_write", 32'(wr_cnt - w0), 32'd1);
    check("t6_good_data",  wr_data_log[w0 % 64], 32'h0000_0001);
    check("t6_good_err",   32'(err_cnt - e0), 32'd1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #(3_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
